dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 19 +
 rtl/dm_arbiter_starve_counter.sv | 42 ++++
 rtl/dm_arbiter.sv | 117 +++++++++++
 tb/tb_dm_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg
//   Shared definitions for the display/debug memory arbiter and any CPU-side
//   wrappers that need the same address/data defaults or grant encoding.
//   Contents:
//     DmAddrW, DmDataW, DmStarveMax : default geometry and starvation limit
//     last_grant_e                  : which requester read the memory last cycle
package dm_arbiter_pkg;

   localparam int unsigned DmAddrW     = 8;
   localparam int unsigned DmDataW     = 16;
   localparam int unsigned DmStarveMax = 8;

   typedef enum logic [1:0] {
      LgNone  = 2'd0,
      LgCpuRd = 2'd1,
      LgDbgRd = 2'd2
   } last_grant_e;

endpackage

// File: rtl/dm_arbiter_starve_counter.sv
// dm_arbiter_starve_counter
//   Saturating up-counter with synchronous clear. Counts how many consecutive
//   cycles the debug requester has been refused.
//   Ports:
//     clk_i, reset_i : clock, asynchronous active-high reset
//     inc_i          : count up this cycle (saturates at MaxCnt)
//     clr_i          : return to zero this cycle (wins over inc_i)
//     at_max_o       : count has reached MaxCnt
module dm_arbiter_starve_counter #(
   parameter int unsigned MaxCnt = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_max_o
);

   localparam int unsigned CntW = (MaxCnt > 0) ? $clog2(MaxCnt + 1) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign at_max_o = (cnt_q == CntW'(MaxCnt));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !at_max_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Two-requester arbiter for a single memory port. The CPU has priority; the
//   debug/display reader is forced through once it has waited STARVE_MAX
//   cycles. Reads complete with one cycle of latency into per-requester
//   registered read data.
//   Ports:
//     clk_i, reset_i                          : clock, asynchronous active-high reset
//     cpu_req_i/we_i/addr_i/wdata_i           : CPU access request
//     cpu_gnt_o, cpu_rdata_o, cpu_rvalid_o    : CPU grant and read return
//     dbg_req_i/addr_i                        : debug read request
//     dbg_gnt_o, dbg_rdata_o, dbg_rvalid_o    : debug grant and read return
//     mem_addr_o/we_o/wdata_o, mem_rdata_i    : memory port (sync write, comb read)
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DmAddrW,
   parameter int unsigned DATA_W     = DmDataW,
   parameter int unsigned STARVE_MAX = DmStarveMax
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_rvalid_o,
   input  logic              dbg_req_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic              dbg_gnt_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              dbg_rvalid_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   last_grant_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              starve_at_max;
   logic              force_dbg;
   logic              dbg_starving;

   // Grants are gated by reset so nothing reaches memory while it is asserted.
   assign force_dbg = dbg_req_i & starve_at_max;
   assign dbg_gnt_o = ~reset_i & dbg_req_i & (~cpu_req_i | force_dbg);
   assign cpu_gnt_o = ~reset_i & cpu_req_i & ~force_dbg;

   assign mem_we_o    = cpu_gnt_o & cpu_we_i;
   assign mem_wdata_o = cpu_wdata_i;

   // Idle cycles keep presenting the last granted address.
   always_comb begin
      mem_addr_o = addr_q;
      if (dbg_gnt_o) begin
         mem_addr_o = dbg_addr_i;
      end else if (cpu_gnt_o) begin
         mem_addr_o = cpu_addr_i;
      end
   end

   // A refused debug request counts up; a grant or a dropped request clears.
   assign dbg_starving = dbg_req_i & ~dbg_gnt_o;

   dm_arbiter_starve_counter #(
      .MaxCnt (STARVE_MAX)
   ) u_starve_counter (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .inc_i    (dbg_starving),
      .clr_i    (~dbg_starving),
      .at_max_o (starve_at_max)
   );

   // Last-grant FSM: next state is the read issued this cycle; rvalid pulses
   // are decoded from the state so a reset drops any in-flight return.
   always_comb begin
      state_d      = LgNone;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      cpu_rvalid_o = 1'b0;
      dbg_rvalid_o = 1'b0;

      if (dbg_gnt_o) begin
         state_d     = LgDbgRd;
         dbg_rdata_d = mem_rdata_i;
      end else if (cpu_gnt_o && !cpu_we_i) begin
         state_d     = LgCpuRd;
         cpu_rdata_d = mem_rdata_i;
      end

      cpu_rvalid_o = (state_q == LgCpuRd);
      dbg_rvalid_o = (state_q == LgDbgRd);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= LgNone;
         addr_q      <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= mem_addr_o;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Self-checking bench for dm_arbiter: directed scenarios followed by
//   randomized traffic, all compared against a behavioural reference model.
module tb_dm_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned SM = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req, cpu_we, dbg_req;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
   logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   dm_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (SM)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_gnt_o    (cpu_gnt),
      .cpu_rdata_o  (cpu_rdata),
      .cpu_rvalid_o (cpu_rvalid),
      .dbg_req_i    (dbg_req),
      .dbg_addr_i   (dbg_addr),
      .dbg_gnt_o    (dbg_gnt),
      .dbg_rdata_o  (dbg_rdata),
      .dbg_rvalid_o (dbg_rvalid),
      .mem_addr_o   (mem_addr),
      .mem_we_o     (mem_we),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   // Memory attached to the DUT, with a preload path used while in reset.
   logic [DW-1:0] env_mem [256];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) env_mem[pl_addr] <= pl_data;
      else if (mem_we) env_mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = env_mem[mem_addr];

   // Reference model state
   logic [DW-1:0] ref_mem [256];
   int            m_starve;
   bit            m_cpu_rv, m_dbg_rv;
   logic [DW-1:0] m_cpu_rd, m_dbg_rd;
   logic [AW-1:0] m_addr;
   bit            obs_dgnt;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic ref_reset();
      m_starve = 0;
      m_cpu_rv = 1'b0;
      m_dbg_rv = 1'b0;
      m_cpu_rd = '0;
      m_dbg_rd = '0;
      m_addr   = '0;
   endtask

   task automatic set_in(input bit cr, input bit cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input bit dr, input logic [AW-1:0] da);
      cpu_req   = cr;
      cpu_we    = cw;
      cpu_addr  = ca;
      cpu_wdata = cd;
      dbg_req   = dr;
      dbg_addr  = da;
   endtask

   // Called just after a falling edge with inputs applied; checks this cycle
   // against the model, advances the model, and returns after the next falling edge.
   task automatic step();
      bit            e_force, e_dg, e_cg, e_we;
      logic [AW-1:0] e_addr;
      #1;
      e_force = dbg_req && (m_starve == SM);
      e_dg    = dbg_req && (!cpu_req || e_force);
      e_cg    = cpu_req && !e_dg;
      e_we    = e_cg && cpu_we;
      e_addr  = e_dg ? dbg_addr : (e_cg ? cpu_addr : m_addr);

      check_val("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
      check_val("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
      check_val("mem_we", 32'(mem_we), 32'(e_we));
      check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check_val("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      check_val("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
      check_val("dbg_rvalid", 32'(dbg_rvalid), 32'(m_dbg_rv));
      check_val("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
      check_val("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rd));
      obs_dgnt = dbg_gnt;

      // Reads see memory before this cycle's write lands.
      m_cpu_rv = e_cg && !cpu_we;
      m_dbg_rv = e_dg;
      if (m_cpu_rv) m_cpu_rd = ref_mem[cpu_addr];
      if (m_dbg_rv) m_dbg_rd = ref_mem[dbg_addr];
      if (e_we) ref_mem[cpu_addr] = cpu_wdata;
      if (dbg_req && !e_dg) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else m_starve = 0;
      m_addr = e_addr;

      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      set_in(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
      ref_reset();
      @(negedge clk);

      // Preload memory under reset; grants must stay low whatever is requested.
      for (int a = 0; a < 256; a++) begin
         logic [DW-1:0] v;
         v = DW'($urandom);
         if (a == 'h10) v = 16'hBEEF;
         if (a == 'h05) v = 16'h00AA;
         if (a == 'h30) v = 16'h1111;
         pl_en   = 1'b1;
         pl_addr = AW'(a);
         pl_data = v;
         ref_mem[a] = v;
         set_in(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                1'($urandom), AW'($urandom));
         #1;
         check_val("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
         check_val("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      pl_en = 1'b0;
      check_val("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check_val("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check_val("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check_val("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;

      // CPU read of 0xBEEF at 0x10, granted in the first cycle out of reset
      set_in(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 8'h00);
      step();
      check_val("r037_rvalid", 32'(cpu_rvalid), 32'd1);
      check_val("r037_rdata", 32'(cpu_rdata), 32'hBEEF);

      // CPU write then read back
      set_in(1'b1, 1'b1, 8'h20, 16'h1234, 1'b0, 8'h00);
      #1 check_val("r038_we", 32'(mem_we), 32'd1);
      step();
      check_val("r038_no_rvalid", 32'(cpu_rvalid), 32'd0);
      set_in(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h00);
      step();
      check_val("r038_rdata", 32'(cpu_rdata), 32'h1234);

      // Debug read alone
      set_in(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h05);
      #1 check_val("r040_gnt", 32'(dbg_gnt), 32'd1);
      step();
      check_val("r040_rvalid", 32'(dbg_rvalid), 32'd1);
      check_val("r040_rdata", 32'(dbg_rdata), 32'h00AA);

      // Both requesting continuously: debug every SM+1 cycles
      set_in(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
      step();
      for (int i = 0; i < 20; i++) begin
         set_in(1'b1, 1'b0, AW'(i), 16'h0000, 1'b1, AW'(i + 100));
         step();
         check_val("r039_dbg_gnt", 32'(obs_dgnt), 32'(i % 9 == 8));
      end

      // Forced debug read collides with a CPU write to the same address
      set_in(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
      step();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 1'b0, AW'(8'h40 + i), 16'h0000, 1'b1, 8'h30);
         step();
      end
      set_in(1'b1, 1'b1, 8'h30, 16'h5555, 1'b1, 8'h30);
      #1;
      check_val("r042_cpu_stall", 32'(cpu_gnt), 32'd0);
      check_val("r042_no_we", 32'(mem_we), 32'd0);
      step();
      check_val("r042_dbg_old", 32'(dbg_rdata), 32'h1111);
      set_in(1'b1, 1'b1, 8'h30, 16'h5555, 1'b0, 8'h00);
      #1 check_val("r042_we_next", 32'(mem_we), 32'd1);
      step();
      set_in(1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 8'h00);
      step();
      check_val("r042_new", 32'(cpu_rdata), 32'h5555);

      // Reset during a CPU read with the starvation count part-way up
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b0, AW'(i), 16'h0000, 1'b1, AW'(i));
         step();
      end
      set_in(1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 8'h11);
      #1 check_val("r041_cpu_gnt", 32'(cpu_gnt), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_val("r041_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check_val("r041_rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_val("r041_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check_val("r041_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check_val("r041_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check_val("r041_dbg_rdata", 32'(dbg_rdata), 32'd0);
      check_val("r041_mem_addr", 32'(mem_addr), 32'd0);
      check_val("r041_mem_we", 32'(mem_we), 32'd0);
      ref_reset();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_in(1'b1, 1'b0, AW'(i), 16'h0000, 1'b1, 8'h05);
         step();
         check_val("r041_starve_cleared", 32'(obs_dgnt), 32'(i == 8));
      end

      // Randomized traffic with sticky requests so starvation is reached
      set_in(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) cpu_req = ~cpu_req;
         if ($urandom_range(0, 7) == 0) dbg_req = ~dbg_req;
         cpu_we    = ($urandom_range(0, 2) == 0);
         cpu_addr  = AW'($urandom_range(0, 15));
         dbg_addr  = AW'($urandom_range(0, 15));
         cpu_wdata = DW'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
